// File: rtl/gyro_frame_deserializer.sv
// gyro_frame_deserializer
//
// Link-side receiver for the gyro high-speed serial channel. It recovers 48-bit
// frames sent MSB-first on DTX. DSYNC (qualified by DVALID) marks the last bit of
// each frame. Each completed frame is split into three 16-bit words and held in a
// 2-entry FIFO, which is drained through a valid/ready handshake.
//
// Optional feature: define GYRO_DESER_ERR_CNT_EN to add the saturating
// framing-error counter and its err_count port.
//
// Ports
//   clock        bit clock; all logic runs on the rising edge
//   reset_n      asynchronous active-low reset
//   enable       receiver enable; 0 forces HUNT and drops any partial frame
//   debug_clear  synchronous clear of the sticky status (overflow, err_count)
//   DTX          serial data, frame MSB first
//   DVALID       bit qualifier; DTX/DSYNC are ignored while 0
//   DSYNC        frame marker; 1 together with DVALID flags bit 47
//   rx0_data     head frame bits [47:32]
//   rx1_data     head frame bits [31:16]
//   rx2_data     head frame bits [15:0]
//   rx_valid     head frame available
//   rx_ready     consumer accepts the head frame
//   locked       1 while in RECV
//   sync_err     registered one-cycle pulse on a framing error
//   overflow     sticky; a completed frame was dropped because the FIFO was full
//   err_count    saturating framing-error count (GYRO_DESER_ERR_CNT_EN only)

module gyro_frame_deserializer (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        debug_clear,
  input  logic        DTX,
  input  logic        DVALID,
  input  logic        DSYNC,
  output logic [15:0] rx0_data,
  output logic [15:0] rx1_data,
  output logic [15:0] rx2_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        locked,
  output logic        sync_err,
  output logic        overflow
`ifdef GYRO_DESER_ERR_CNT_EN
  ,
  output logic [15:0] err_count
`endif
);

  localparam logic [0:0] StHunt = 1'b0;
  localparam logic [0:0] StRecv = 1'b1;

  localparam logic [5:0] LastBit = 6'd47;

  // Receiver state
  logic [0:0]  state_q, state_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  // Only 47 bits need storing: the 48th arrives on DTX in the completing cycle.
  logic [46:0] sr_q, sr_d;

  logic        frame_push;
  logic        err_event;
  logic [47:0] frame_word;

  assign frame_word = {sr_q, DTX};

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    sr_d       = sr_q;
    frame_push = 1'b0;
    err_event  = 1'b0;

    if (!enable) begin
      state_d   = StHunt;
      bit_cnt_d = '0;
      sr_d      = '0;
    end else begin
      case (state_q)
        StHunt: begin
          bit_cnt_d = '0;
          sr_d      = '0;
          // The marker bit itself closes an unknown frame and is discarded.
          if (DVALID && DSYNC) begin
            state_d = StRecv;
          end
        end
        StRecv: begin
          if (DVALID) begin
            if (DSYNC) begin
              // DSYNC is always a trustworthy boundary: realign on it even if short.
              frame_push = (bit_cnt_q == LastBit);
              err_event  = (bit_cnt_q != LastBit);
              bit_cnt_d  = '0;
              sr_d       = '0;
            end else if (bit_cnt_q == LastBit) begin
              // Marker missing where one was due: alignment is lost.
              err_event = 1'b1;
              state_d   = StHunt;
              bit_cnt_d = '0;
              sr_d      = '0;
            end else begin
              sr_d      = {sr_q[45:0], DTX};
              bit_cnt_d = bit_cnt_q + 6'd1;
            end
          end
        end
        default: begin
          state_d   = StHunt;
          bit_cnt_d = '0;
          sr_d      = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StHunt;
      bit_cnt_q <= '0;
      sr_q      <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      sr_q      <= sr_d;
    end
  end

  assign locked = (state_q == StRecv);

  // Two-entry frame FIFO
  logic [47:0] mem_q [2];
  logic        wr_ptr_q, rd_ptr_q;
  logic [1:0]  cnt_q, cnt_d;
  logic        pop, full, push_ok, ovf_event;
  logic [47:0] head;

  assign pop       = (cnt_q != 2'd0) && rx_ready;
  assign full      = (cnt_q == 2'd2);
  // A pop in the same cycle frees the slot the push needs.
  assign push_ok   = frame_push && (!full || pop);
  assign ovf_event = frame_push && full && !pop;

  always_comb begin
    cnt_d = cnt_q;
    if (push_ok && !pop) begin
      cnt_d = cnt_q + 2'd1;
    end else if (!push_ok && pop) begin
      cnt_d = cnt_q - 2'd1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= frame_word;
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_d;
    end
  end

  assign head     = mem_q[rd_ptr_q];
  assign rx0_data = head[47:32];
  assign rx1_data = head[31:16];
  assign rx2_data = head[15:0];
  assign rx_valid = (cnt_q != 2'd0);

  // Status
  logic sync_err_q;
  logic overflow_q, overflow_d;

  // An overflow in the same cycle as debug_clear must not be lost.
  always_comb begin
    overflow_d = overflow_q;
    if (ovf_event) begin
      overflow_d = 1'b1;
    end else if (debug_clear) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_err_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      sync_err_q <= err_event;
      overflow_q <= overflow_d;
    end
  end

  assign sync_err = sync_err_q;
  assign overflow = overflow_q;

`ifdef GYRO_DESER_ERR_CNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  // Counts in step with the sync_err pulse; an error beats a simultaneous clear.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_event) begin
      if (err_cnt_q != 16'hFFFF) begin
        err_cnt_d = err_cnt_q + 16'd1;
      end
    end else if (debug_clear) begin
      err_cnt_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_gyro_frame_deserializer.sv
// Self-checking bench for gyro_frame_deserializer. A frame-level reference model
// (bit queue + frame queue) predicts every output each cycle.
module tb_gyro_frame_deserializer;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b0;
  logic        debug_clear = 1'b0;
  logic        DTX = 1'b0;
  logic        DVALID = 1'b0;
  logic        DSYNC = 1'b0;
  logic        rx_ready = 1'b0;
  logic [15:0] rx0_data, rx1_data, rx2_data;
  logic        rx_valid, locked, sync_err, overflow;
`ifdef GYRO_DESER_ERR_CNT_EN
  logic [15:0] err_count;
`endif

  gyro_frame_deserializer dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .enable      (enable),
    .debug_clear (debug_clear),
    .DTX         (DTX),
    .DVALID      (DVALID),
    .DSYNC       (DSYNC),
    .rx0_data    (rx0_data),
    .rx1_data    (rx1_data),
    .rx2_data    (rx2_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .locked      (locked),
    .sync_err    (sync_err),
    .overflow    (overflow)
`ifdef GYRO_DESER_ERR_CNT_EN
    ,
    .err_count   (err_count)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, obs, exp);
    end
  endtask

  // Reference model
  bit          m_locked;
  bit          m_bits[$];
  logic [47:0] mq[$];
  bit          m_ovf;
  bit          m_err;
  int          m_cnt;
  int          rdy_mode;  // 0 low, 1 high, 2 random, 3 high only on a frame's last bit

  task automatic model_clear();
    m_locked = 0;
    m_bits.delete();
    mq.delete();
    m_ovf = 0;
    m_err = 0;
    m_cnt = 0;
  endtask

  task automatic compare_all();
    logic [47:0] h;
    check_eq("rx_valid", rx_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      h = mq[0];
      check_eq("rx_data", {rx0_data, rx1_data, rx2_data}, h);
    end
    check_eq("locked", locked, m_locked);
    check_eq("sync_err", sync_err, m_err);
    check_eq("overflow", overflow, m_ovf);
`ifdef GYRO_DESER_ERR_CNT_EN
    check_eq("err_count", err_count, m_cnt);
`endif
  endtask

  // One clock: drive inputs, predict, then compare after the edge.
  task automatic step(input bit en, input bit dv, input bit dtx, input bit ds, input bit rdy,
                      input bit clr);
    bit          pop, push, err, ovf;
    logic [47:0] val;
    enable = en; DVALID = dv; DTX = dtx; DSYNC = ds; rx_ready = rdy; debug_clear = clr;
    pop = (mq.size() != 0) && rdy;
    push = 0; err = 0; ovf = 0; val = '0;
    if (!en) begin
      m_locked = 0;
      m_bits.delete();
    end else if (!m_locked) begin
      if (dv && ds) begin
        m_locked = 1;
        m_bits.delete();
      end
    end else if (dv) begin
      if (ds) begin
        if (m_bits.size() == 47) begin
          foreach (m_bits[i]) val = {val[46:0], m_bits[i]};
          val  = {val[46:0], dtx};
          push = 1;
        end else begin
          err = 1;
        end
        m_bits.delete();
      end else if (m_bits.size() == 47) begin
        err = 1;
        m_locked = 0;
        m_bits.delete();
      end else begin
        m_bits.push_back(dtx);
      end
    end
    if (pop) void'(mq.pop_front());
    if (push) begin
      if (mq.size() < 2) mq.push_back(val);
      else ovf = 1;
    end
    if (ovf) m_ovf = 1;
    else if (clr) m_ovf = 0;
    m_err = err;
    if (err) begin
      if (m_cnt < 65535) m_cnt++;
    end else if (clr) begin
      m_cnt = 0;
    end
    @(posedge clock);
    #1;
    compare_all();
  endtask

  function automatic bit pick_rdy(input bit last);
    case (rdy_mode)
      0: return 1'b0;
      1: return 1'b1;
      2: return 1'($urandom_range(0, 1));
      default: return last;
    endcase
  endfunction

  task automatic idle(input int n, input bit rdy);
    for (int k = 0; k < n; k++) step(1, 0, 0, 0, rdy, 0);
  endtask

  task automatic send_bits(input logic [47:0] f, input int nbits, input bit sync_last,
                           input int maxgap);
    for (int i = 0; i < nbits; i++) begin
      if (maxgap > 0) begin
        int g = $urandom_range(0, maxgap);
        for (int k = 0; k < g; k++)
          step(1, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pick_rdy(0), 0);
      end
      step(1, 1, f[47-i], sync_last && (i == nbits - 1), pick_rdy(i == nbits - 1), 0);
    end
  endtask

  task automatic sync_only();
    step(1, 1, 0, 1, pick_rdy(0), 0);
  endtask

  function automatic logic [47:0] rand_frame();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[47:0];
  endfunction

  task automatic do_reset();
    #2;
    reset_n = 0;
    enable = 0;
    #1;
    model_clear();
    compare_all();
    check_eq("rst_rx0", rx0_data, 16'h0);
    check_eq("rst_rx1", rx1_data, 16'h0);
    check_eq("rst_rx2", rx2_data, 16'h0);
    @(posedge clock);
    #1;
    reset_n = 1;
  endtask

  initial begin
    logic [47:0] f;
    model_clear();
    rdy_mode = 0;
    do_reset();

    // Directed first frame
    sync_only();
    check_eq("locked_after_sync", locked, 1'b1);
    send_bits(48'h1234_5678_9ABC, 48, 1, 0);
    check_eq("lat_valid", rx_valid, 1'b1);
    check_eq("rx0_1234", rx0_data, 16'h1234);
    check_eq("rx1_5678", rx1_data, 16'h5678);
    check_eq("rx2_9abc", rx2_data, 16'h9ABC);
    idle(1, 1);

    // Three frames with no consumer: third is dropped
    for (int n = 0; n < 3; n++) send_bits(rand_frame(), 48, 1, 0);
    check_eq("ovf_set", overflow, 1'b1);
    idle(3, 1);
    check_eq("drained", rx_valid, 1'b0);
    step(1, 0, 0, 0, 0, 1);
    check_eq("ovf_clr", overflow, 1'b0);

    // Early DSYNC at bit_cnt 20
    rdy_mode = 1;
    send_bits(rand_frame(), 21, 1, 0);
    check_eq("early_sync_err", sync_err, 1'b1);
    send_bits(rand_frame(), 48, 1, 0);
`ifdef GYRO_DESER_ERR_CNT_EN
    check_eq("err_count_1", err_count, 16'd1);
`endif

    // Missing DSYNC at bit 47
    send_bits(rand_frame(), 48, 0, 0);
    check_eq("miss_sync_err", sync_err, 1'b1);
    check_eq("miss_unlock", locked, 1'b0);
    sync_only();
    send_bits(rand_frame(), 48, 1, 0);

    // Gapped frame gives identical words
    rdy_mode = 0;
    idle(2, 1);
    send_bits(48'hA5C3_0FF0_1E2D, 48, 1, 5);
    check_eq("gap_rx0", rx0_data, 16'hA5C3);
    check_eq("gap_rx1", rx1_data, 16'h0FF0);
    check_eq("gap_rx2", rx2_data, 16'h1E2D);
    idle(1, 1);

    // Push and pop together while full
    send_bits(rand_frame(), 48, 1, 0);
    send_bits(rand_frame(), 48, 1, 0);
    rdy_mode = 3;
    send_bits(rand_frame(), 48, 1, 0);
    check_eq("full_pushpop_ovf", overflow, 1'b0);
    rdy_mode = 0;
    idle(1, 0);

    // enable=0 mid-frame; buffered frames still drain
    send_bits(rand_frame(), 10, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    check_eq("dis_unlock", locked, 1'b0);
    check_eq("dis_keep_valid", rx_valid, 1'b1);
    idle(3, 1);

    // Reset mid-frame
    sync_only();
    send_bits(rand_frame(), 20, 0, 0);
    do_reset();

    // Randomized traffic
    rdy_mode = 2;
    for (int it = 0; it < 60; it++) begin
      int kind = $urandom_range(0, 11);
      if (!m_locked) sync_only();
      f = rand_frame();
      case (kind)
        8:  send_bits(f, $urandom_range(1, 47), 1, 2);
        9:  send_bits(f, 48, 0, 2);
        10: begin
          send_bits(f, $urandom_range(1, 40), 0, 1);
          step(0, 1, 0, 0, pick_rdy(0), 0);
        end
        11: step(1, 0, 0, 0, pick_rdy(0), 1);
        default: send_bits(f, 48, 1, $urandom_range(0, 3));
      endcase
    end
    idle(4, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
